// File: rtl/accelerator_dnc_pkg.sv
// Shared types and constants for the DNC read-head streaming blocks.
//   state_e   : FSM states of the read-key stream (IDLE, RUN, DRAIN, DONE)
//   key_tag_t : per-element tag carried alongside each key through the FIFO
//   CTRL_* / DATA_* : zero/one constants for control and data paths
package accelerator_dnc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Tag index fields are sized for the widest supported CONTROL_SIZE.
  localparam int unsigned TAG_IDX_W = 64;

  localparam logic [63:0] CTRL_ZERO = 64'd0;
  localparam logic [63:0] CTRL_ONE  = 64'd1;
  localparam logic [63:0] DATA_ZERO = 64'd0;

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic [TAG_IDX_W-1:0] i;
    logic [TAG_IDX_W-1:0] k;
  } key_tag_t;

endpackage

// File: rtl/accelerator_read_keys_stream_if.sv
// Control and key-stream bundle for accelerator_read_keys_stream.
//   slave  : the stream block (consumes START/sizes/K_IN, produces K_OUT and status)
//   master : the environment driving the block
interface accelerator_read_keys_stream_if #(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64
);
  logic                    START;
  logic                    READY;
  logic                    BUSY;
  logic                    ERROR;
  logic [DATA_SIZE-1:0]    SIZE_R_IN;
  logic [DATA_SIZE-1:0]    SIZE_W_IN;
  logic [DATA_SIZE-1:0]    K_IN;
  logic                    K_IN_VALID;
  logic                    K_IN_READY;
  logic [DATA_SIZE-1:0]    K_OUT;
  logic                    K_OUT_VALID;
  logic                    K_OUT_READY;
  logic                    K_OUT_I_ENABLE;
  logic                    K_OUT_K_ENABLE;
  logic                    K_OUT_LAST;
  logic [CONTROL_SIZE-1:0] INDEX_I_OUT;
  logic [CONTROL_SIZE-1:0] INDEX_K_OUT;

  modport slave (
    input  START, SIZE_R_IN, SIZE_W_IN, K_IN, K_IN_VALID, K_OUT_READY,
    output READY, BUSY, ERROR, K_IN_READY, K_OUT, K_OUT_VALID,
           K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT_LAST, INDEX_I_OUT, INDEX_K_OUT
  );

  modport master (
    output START, SIZE_R_IN, SIZE_W_IN, K_IN, K_IN_VALID, K_OUT_READY,
    input  READY, BUSY, ERROR, K_IN_READY, K_OUT, K_OUT_VALID,
           K_OUT_I_ENABLE, K_OUT_K_ENABLE, K_OUT_LAST, INDEX_I_OUT, INDEX_K_OUT
  );
endinterface

// File: rtl/accelerator_fifo_tagged.sv
// Synchronous FIFO with registered storage and a combinational head.
//   clk, rst        : clock, asynchronous active-high reset
//   push, push_data : write request and payload (ignored when full)
//   pop             : read request (ignored when empty)
//   head_data       : oldest entry, valid while !empty
//   full, empty     : occupancy flags
module accelerator_fifo_tagged #(
  parameter int FIFO_DEPTH = 4,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty
);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [WIDTH-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push_s, do_pop_s;

  // Storage, pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < FIFO_DEPTH; j++) mem_q[j] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Next pointer/occupancy/storage values; pointers wrap since depth is a power of two
  always_comb begin
    do_push_s = push && !full;
    do_pop_s  = pop && !empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Status flags and head entry
  always_comb begin
    full      = (count_q == CNT_W'(FIFO_DEPTH));
    empty     = (count_q == CNT_W'(0));
    head_data = mem_q[rd_ptr_q];
  end
endmodule

// File: rtl/accelerator_read_keys_stream.sv
// Streams read keys k(t;i;k), i in 0..R-1, k in 0..W-1, from the controller
// interface to the content-addressing stage through a tagged FIFO.
//   CLK, RST : clock, asynchronous active-high reset
//   bus      : START/READY/BUSY/ERROR control, SIZE_R_IN/SIZE_W_IN, K_IN
//              valid/ready input stream, K_OUT valid/ready output stream
//              with I/K enables, LAST and INDEX_I/INDEX_K tags
module accelerator_read_keys_stream
  import accelerator_dnc_pkg::*;
#(
  parameter int DATA_SIZE    = 64,
  parameter int CONTROL_SIZE = 64,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                           CLK,
  input  logic                           RST,
  accelerator_read_keys_stream_if.slave  bus
);
  typedef struct packed {
    logic [DATA_SIZE-1:0] data;
    key_tag_t             tag;
  } entry_t;

  localparam int PAYLOAD_W = $bits(entry_t);

  state_e                  state_q, state_d;
  logic [CONTROL_SIZE-1:0] r_q, r_d, w_q, w_d, i_q, i_d, k_q, k_d;
  logic                    err_q, err_d;
  logic [CONTROL_SIZE-1:0] size_r_s, size_w_s;
  logic                    size_zero_s, last_in_s, k_wrap_s;
  logic                    k_in_ready_s, push_s, pop_s, pop_last_s;
  logic                    full_s, empty_s;
  entry_t                  push_entry_s, head_s;

  // Sizes are truncated to the counter width; completion is detected from
  // the counters, so R*W is never formed.
  always_comb begin
    size_r_s     = CONTROL_SIZE'(bus.SIZE_R_IN);
    size_w_s     = CONTROL_SIZE'(bus.SIZE_W_IN);
    size_zero_s  = (size_r_s == CONTROL_SIZE'(CTRL_ZERO)) || (size_w_s == CONTROL_SIZE'(CTRL_ZERO));
    k_wrap_s     = (k_q == w_q - CONTROL_SIZE'(CTRL_ONE));
    last_in_s    = k_wrap_s && (i_q == r_q - CONTROL_SIZE'(CTRL_ONE));
    k_in_ready_s = (state_q == RUN) && !full_s;
    push_s       = bus.K_IN_VALID && k_in_ready_s;
    pop_s        = !empty_s && bus.K_OUT_READY;
    pop_last_s   = pop_s && head_s.tag.last;
    push_entry_s.data      = bus.K_IN;
    push_entry_s.tag.first = (k_q == CONTROL_SIZE'(CTRL_ZERO));
    push_entry_s.tag.last  = last_in_s;
    push_entry_s.tag.i     = TAG_IDX_W'(i_q);
    push_entry_s.tag.k     = TAG_IDX_W'(k_q);
  end

  // State, latched sizes, loop counters and error flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      r_q     <= '0;
      w_q     <= '0;
      i_q     <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      w_q     <= w_d;
      i_q     <= i_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic; a last pop in RUN can only follow a completed input
  // phase, so it is allowed to jump straight to DONE
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          state_d = size_zero_s ? DONE : RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (pop_last_s) begin
          state_d = DONE;
        end else if (push_s && last_in_s) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (pop_last_s) begin
          state_d = DONE;
        end else begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Size latch, counter advance on push, error flag set/clear
  always_comb begin
    r_d   = r_q;
    w_d   = w_q;
    i_d   = i_q;
    k_d   = k_q;
    err_d = err_q;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          r_d   = size_r_s;
          w_d   = size_w_s;
          i_d   = CONTROL_SIZE'(CTRL_ZERO);
          k_d   = CONTROL_SIZE'(CTRL_ZERO);
          err_d = size_zero_s;
        end else begin
          err_d = err_q;
        end
      end
      RUN: begin
        if (push_s && k_wrap_s) begin
          k_d = CONTROL_SIZE'(CTRL_ZERO);
          i_d = i_q + CONTROL_SIZE'(CTRL_ONE);
        end else if (push_s) begin
          k_d = k_q + CONTROL_SIZE'(CTRL_ONE);
        end else begin
          k_d = k_q;
        end
      end
      DONE:    err_d = 1'b0;
      default: err_d = err_q;
    endcase
  end

  // Outputs; head fields are forced to zero while the FIFO is empty
  always_comb begin
    bus.READY          = (state_q == DONE);
    bus.ERROR          = (state_q == DONE) && err_q;
    bus.BUSY           = (state_q != IDLE);
    bus.K_IN_READY     = k_in_ready_s;
    bus.K_OUT_VALID    = !empty_s;
    bus.K_OUT_K_ENABLE = !empty_s;
    bus.K_OUT_I_ENABLE = !empty_s && head_s.tag.first;
    bus.K_OUT_LAST     = !empty_s && head_s.tag.last;
    if (empty_s) begin
      bus.K_OUT       = DATA_SIZE'(DATA_ZERO);
      bus.INDEX_I_OUT = CONTROL_SIZE'(CTRL_ZERO);
      bus.INDEX_K_OUT = CONTROL_SIZE'(CTRL_ZERO);
    end else begin
      bus.K_OUT       = head_s.data;
      bus.INDEX_I_OUT = CONTROL_SIZE'(head_s.tag.i);
      bus.INDEX_K_OUT = CONTROL_SIZE'(head_s.tag.k);
    end
  end

  accelerator_fifo_tagged #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (PAYLOAD_W)
  ) u_fifo (
    .clk       (CLK),
    .rst       (RST),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (push_entry_s),
    .head_data (head_s),
    .full      (full_s),
    .empty     (empty_s)
  );
endmodule

// File: tb/tb_accelerator_read_keys_stream.sv
module tb_accelerator_read_keys_stream;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  accelerator_read_keys_stream_if #(.DATA_SIZE(64), .CONTROL_SIZE(64)) bus ();

  accelerator_read_keys_stream #(
    .DATA_SIZE(64), .CONTROL_SIZE(64), .FIFO_DEPTH(4)
  ) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Starts an R x W transfer, streams base+n as element n, and scores every pop.
  task automatic run_stream(input int r, input int w, input int stall, input bit rnd,
                            input bit poke, input logic [63:0] base);
    int total, in_n, out_n, ready_cnt, cyc;
    total = r * w; in_n = 0; out_n = 0; ready_cnt = 0;
    bus.SIZE_R_IN = 64'(r); bus.SIZE_W_IN = 64'(w); bus.START = 1'b1;
    bus.K_IN_VALID = 1'b0; bus.K_OUT_READY = 1'b0;
    @(negedge clk);
    bus.START = 1'b0; bus.SIZE_R_IN = 64'd0; bus.SIZE_W_IN = 64'd0;
    chk("busy_run", bus.BUSY, 64'd1);
    chk("kin_ready_run", bus.K_IN_READY, 64'd1);
    for (cyc = 0; cyc < 3000; cyc++) begin
      bus.K_IN_VALID  = (in_n < total) && (rnd ? ($urandom_range(0, 1) == 1) : 1'b1);
      bus.K_IN        = base + 64'(in_n);
      bus.K_OUT_READY = (cyc < stall) ? 1'b0 : (rnd ? ($urandom_range(0, 2) != 0) : 1'b1);
      bus.START       = poke && (cyc == 2);
      bus.SIZE_R_IN   = (poke && cyc == 2) ? 64'd7 : 64'd0;
      bus.SIZE_W_IN   = (poke && cyc == 2) ? 64'd7 : 64'd0;
      if (cyc == 0) chk("first_latency", bus.K_OUT_VALID, 64'd0);
      if (cyc >= 1 && cyc < stall) chk("stall_hold", bus.K_OUT, base);
      if (stall > 4 && cyc == stall - 1) begin
        chk("stall_pushes", 64'(in_n), 64'd4);
        chk("stall_kin_ready", bus.K_IN_READY, 64'd0);
      end
      if (bus.K_OUT_VALID && bus.K_OUT_READY) begin
        chk("k_out", bus.K_OUT, base + 64'(out_n));
        chk("idx_i", bus.INDEX_I_OUT, 64'(out_n / w));
        chk("idx_k", bus.INDEX_K_OUT, 64'(out_n % w));
        chk("i_enable", bus.K_OUT_I_ENABLE, 64'((out_n % w) == 0));
        chk("k_enable", bus.K_OUT_K_ENABLE, 64'd1);
        chk("last", bus.K_OUT_LAST, 64'(out_n == total - 1));
        chk("ready_early", bus.READY, 64'd0);
        out_n++;
      end
      if (bus.K_IN_VALID && bus.K_IN_READY) in_n++;
      @(negedge clk);
      if (bus.READY) begin
        ready_cnt++;
        chk("error_low", bus.ERROR, 64'd0);
        break;
      end
    end
    bus.K_IN_VALID = 1'b0; bus.K_OUT_READY = 1'b0; bus.START = 1'b0;
    bus.SIZE_R_IN = 64'd0; bus.SIZE_W_IN = 64'd0;
    chk("ready_seen", 64'(ready_cnt), 64'd1);
    chk("pushed_all", 64'(in_n), 64'(total));
    chk("popped_all", 64'(out_n), 64'(total));
    if (!rnd && stall == 0) chk("no_bubbles", 64'(cyc), 64'(total));
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("ready_single", bus.READY, 64'd0);
      chk("idle_busy", bus.BUSY, 64'd0);
      chk("idle_valid", bus.K_OUT_VALID, 64'd0);
    end
  endtask

  task automatic zero_size(input logic [63:0] r, input logic [63:0] w);
    bus.SIZE_R_IN = r; bus.SIZE_W_IN = w; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0; bus.SIZE_R_IN = 64'd0; bus.SIZE_W_IN = 64'd0;
    chk("zs_ready", bus.READY, 64'd1);
    chk("zs_error", bus.ERROR, 64'd1);
    chk("zs_busy", bus.BUSY, 64'd1);
    chk("zs_kin_ready", bus.K_IN_READY, 64'd0);
    @(negedge clk);
    chk("zs_ready_end", bus.READY, 64'd0);
    chk("zs_error_end", bus.ERROR, 64'd0);
    chk("zs_busy_end", bus.BUSY, 64'd0);
    chk("zs_kin_ready_end", bus.K_IN_READY, 64'd0);
  endtask

  initial begin
    rst = 1'b1;
    bus.START = 1'b0; bus.SIZE_R_IN = 64'd0; bus.SIZE_W_IN = 64'd0;
    bus.K_IN = 64'd0; bus.K_IN_VALID = 1'b0; bus.K_OUT_READY = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_ready", bus.READY, 64'd0);
    chk("rst_busy", bus.BUSY, 64'd0);
    chk("rst_error", bus.ERROR, 64'd0);
    chk("rst_kin_ready", bus.K_IN_READY, 64'd0);
    chk("rst_valid", bus.K_OUT_VALID, 64'd0);
    chk("rst_kout", bus.K_OUT, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // R=2, W=3, values 1..6, downstream always ready
    run_stream(2, 3, 0, 1'b0, 1'b0, 64'd1);
    // R=1, W=8, downstream stalled for 10 cycles
    run_stream(1, 8, 10, 1'b0, 1'b0, 64'd1);
    // Zero-size error path on W and on R
    zero_size(64'd2, 64'd0);
    zero_size(64'd0, 64'd3);
    // R=3, W=5 with random handshakes on both sides
    run_stream(3, 5, 0, 1'b1, 1'b0, 64'h500);

    // Reset in the middle of a 2x3 transfer after three pushes
    bus.SIZE_R_IN = 64'd2; bus.SIZE_W_IN = 64'd3; bus.START = 1'b1;
    @(negedge clk);
    bus.START = 1'b0; bus.K_OUT_READY = 1'b0;
    for (int n = 0; n < 3; n++) begin
      bus.K_IN = 64'h300 + 64'(n); bus.K_IN_VALID = 1'b1;
      @(negedge clk);
    end
    bus.K_IN_VALID = 1'b0;
    chk("pre_rst_valid", bus.K_OUT_VALID, 64'd1);
    chk("pre_rst_kout", bus.K_OUT, 64'h300);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", bus.K_OUT_VALID, 64'd0);
    chk("mid_rst_kout", bus.K_OUT, 64'd0);
    chk("mid_rst_busy", bus.BUSY, 64'd0);
    chk("mid_rst_kin_ready", bus.K_IN_READY, 64'd0);
    chk("mid_rst_ienable", bus.K_OUT_I_ENABLE, 64'd0);
    chk("mid_rst_ready", bus.READY, 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("post_rst_ready", bus.READY, 64'd0);
      chk("post_rst_valid", bus.K_OUT_VALID, 64'd0);
    end
    run_stream(2, 3, 0, 1'b0, 1'b0, 64'h700);

    // START pulsed with different sizes during RUN must be ignored
    run_stream(2, 4, 0, 1'b0, 1'b1, 64'h900);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
